program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Writer side of the instruction memory. It receives a serial byte stream from the host UART receiver and assembles big-endian 32-bit words. It writes those words into the writable program memory at consecutive word addresses, holding the MIPS core in reset while loading. It sits between the UART RX block and the program memory write port.

Parameters:
MEMORY_DEPTH, 32, number of instruction words the program memory holds; maximum accepted word count.
DATA_WIDTH, 32, instruction/address width.
BASE_ADDRESS, 0, byte address of the first word written.
TIMEOUT_CYCLES, 50000, idle cycles tolerated between bytes while loading.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a load frame
rx_data  input  8  received byte
rx_valid  input  1  one-cycle strobe, rx_data valid
mem_write  output  1  one-cycle write enable to program memory
mem_address  output  DATA_WIDTH  byte address of write (word-aligned, bits[1:0]=0)
mem_write_data  output  DATA_WIDTH  word to write
busy  output  1  load in progress
done  output  1  last frame completed successfully (sticky until next start)
error  output  1  last frame aborted (sticky until next start)
words_loaded  output  16  words written in current/last frame
cpu_hold  output  1  holds MIPS core in reset

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; internal counters 0. Memory contents untouched.
- Frame format: 2-byte word count N (MSB first), then 4*N data bytes, each word MSB first.
- States: IDLE, COUNT_HI, COUNT_LO, DATA, DONE, ERROR.
- IDLE/DONE/ERROR with start=1: next cycle enter COUNT_HI. Set busy=1 and cpu_hold=1. Clear done, error, words_loaded, byte index and timeout counter. rx_valid is ignored in these states.
- start while busy=1: ignored.
- COUNT_HI: rx_valid captures count[15:8] and moves to COUNT_LO.
- COUNT_LO: rx_valid captures count[7:0].
  - If N==0 or N>MEMORY_DEPTH: go to ERROR.
  - Otherwise go to DATA.
- DATA byte assembly: each rx_valid does shift <= {shift[23:0], rx_data} and byte index 0..3 increments.
- On the 4th byte, mem_write_data loads the completed word. On the following cycle, mem_write=1 for exactly one cycle.
- During the write cycle, mem_address = BASE_ADDRESS + 4*words_loaded, truncated to DATA_WIDTH.
- words_loaded increments at the end of the write cycle.
- Assembly register is independent of mem_write_data: a byte arriving in the write cycle is captured as byte 0 of the next word; no byte is lost at one byte per cycle.
- After the write of word N: state DONE, done=1, busy=0, cpu_hold=0.
- Timeout: the counter runs while busy and clears on every accepted byte. If it reaches TIMEOUT_CYCLES-1 with no rx_valid, go to ERROR. rx_valid in the same cycle wins over timeout.
- ERROR: error=1, busy=0, cpu_hold stays 1 (partial program never runs), no further writes. Exit only via start or reset.
- Reset mid-frame: immediate return to IDLE, cpu_hold=0, any pending mem_write suppressed.
- Outputs are registered; mem_address and mem_write_data are stable for the entire mem_write cycle.

Test Plan:
1. Normal load.
   - Stimulus: start, then bytes 00 02 12 34 56 78 AA BB CC DD.
   - Response: mem_write pulses with 0x12345678@0x0 and 0xAABBCCDD@0x4. Then done=1, busy=0, cpu_hold=0, words_loaded=2.
2. Zero count.
   - Stimulus: start, bytes 00 00.
   - Response: error=1 the cycle after the second byte; no mem_write; cpu_hold=1.
3. Overflow count.
   - Stimulus: start, bytes 00 21 (33 > 32).
   - Response: error=1.
   - Follow-up: a new start with count 00 20 and 128 bytes loads 32 words, last at 0x7C, done=1.
4. Timeout.
   - Setup: TIMEOUT_CYCLES=16.
   - Stimulus: start, bytes 00 01 AB CD, then silence.
   - Response: error=1 exactly 16 cycles after byte CD; no mem_write.
   - Corner: a byte on the terminal cycle prevents the error.
5. Back-to-back bytes and ignored start.
   - Stimulus: rx_valid every cycle for count 00 03 plus 12 data bytes.
   - Response: 3 writes at 0x0/0x4/0x8 with correct data; words_loaded=3.
   - Corner: a start pulse mid-frame is ignored.
6. Reset mid-frame.
   - Stimulus: assert reset after 5 data bytes.
   - Response: all outputs 0 asynchronously.
   - Follow-up: a subsequent start with 00 01 01 02 03 04 writes 0x01020304@0x0.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
//   Writer side of the instruction memory. Takes a serial byte stream from the
//   host UART receiver, assembles big-endian 32-bit words and writes them to
//   consecutive word addresses of the program memory, holding the MIPS core in
//   reset while a load is in progress.
//
//   Frame: 2-byte word count N (MSB first), then 4*N data bytes (MSB first).
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high reset
//   start          in   one-cycle pulse, begins a load frame (ignored while busy)
//   rx_data        in   received byte
//   rx_valid       in   one-cycle strobe, rx_data valid
//   mem_write      out  one-cycle program memory write enable
//   mem_address    out  byte address of the write (word aligned)
//   mem_write_data out  word to write
//   busy           out  load in progress
//   done           out  last frame completed (sticky until next start)
//   error          out  last frame aborted (sticky until next start)
//   words_loaded   out  words written in current/last frame
//   cpu_hold       out  holds the MIPS core in reset
//
// State table
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | after reset, waiting for start
//   S_COUNT_HI| waiting for word-count high byte
//   S_COUNT_LO| waiting for word-count low byte, range-checks the count
//   S_DATA    | assembling data bytes and issuing memory writes
//   S_DONE    | frame complete, core released, waiting for start
//   S_ERROR   | frame aborted, core kept in reset, waiting for start

module program_loader #(
  parameter int unsigned MEMORY_DEPTH   = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BASE_ADDRESS   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded,
  output logic                  cpu_hold
);

  // Idle timer is a down-counter reloaded on every accepted byte; the
  // terminal count (zero) corresponds to TIMEOUT_CYCLES-1 idle cycles seen.
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_COUNT_HI = 3'd1,
    S_COUNT_LO = 3'd2,
    S_DATA     = 3'd3,
    S_DONE     = 3'd4,
    S_ERROR    = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            count_hi_q, count_hi_d;
  logic [15:0]           count_q, count_d;
  logic [23:0]           shift_q, shift_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  mem_write_q, mem_write_d;
  logic [DATA_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [15:0]           words_loaded_q, words_loaded_d;
  logic                  cpu_hold_q, cpu_hold_d;

  logic                  timeout;
  logic [15:0]           count_n;
  logic [DATA_WIDTH-1:0] addr_next;

  always_comb begin
    state_d          = state_q;
    count_hi_d       = count_hi_q;
    count_d          = count_q;
    shift_d          = shift_q;
    byte_idx_d       = byte_idx_q;
    tmo_d            = tmo_q;
    mem_write_d      = 1'b0;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    busy_d           = busy_q;
    done_d           = done_q;
    error_d          = error_q;
    words_loaded_d   = words_loaded_q;
    cpu_hold_d       = cpu_hold_q;

    count_n   = {count_hi_q, rx_data};
    addr_next = DATA_WIDTH'(BASE_ADDRESS) + (DATA_WIDTH'(words_loaded_q) << 2);

    // A byte in the terminal cycle wins over the timeout.
    timeout = busy_q && !rx_valid && (tmo_q == '0);
    if (busy_q) begin
      if (rx_valid) begin
        tmo_d = TMO_LOAD;
      end else if (tmo_q != '0) begin
        tmo_d = tmo_q - 1'b1;
      end
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d        = S_COUNT_HI;
          busy_d         = 1'b1;
          cpu_hold_d     = 1'b1;
          done_d         = 1'b0;
          error_d        = 1'b0;
          words_loaded_d = '0;
          byte_idx_d     = '0;
          tmo_d          = TMO_LOAD;
        end
      end

      S_COUNT_HI: begin
        if (timeout) begin
          state_d = S_ERROR;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else if (rx_valid) begin
          count_hi_d = rx_data;
          state_d    = S_COUNT_LO;
        end
      end

      S_COUNT_LO: begin
        if (timeout) begin
          state_d = S_ERROR;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else if (rx_valid) begin
          count_d = count_n;
          if ((count_n == 16'd0) || (count_n > 16'(MEMORY_DEPTH))) begin
            state_d = S_ERROR;
            error_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (mem_write_q) begin
          words_loaded_d = words_loaded_q + 16'd1;
        end
        if (mem_write_q && ((words_loaded_q + 16'd1) == count_q)) begin
          state_d    = S_DONE;
          done_d     = 1'b1;
          busy_d     = 1'b0;
          cpu_hold_d = 1'b0;
        end else if (timeout) begin
          // cpu_hold stays set so a partial program never runs.
          state_d = S_ERROR;
          error_d = 1'b1;
          busy_d  = 1'b0;
        end else if (rx_valid) begin
          // Assembly shifter is separate from mem_write_data, so a byte
          // landing in the write cycle simply starts the next word.
          shift_d    = {shift_q[15:0], rx_data};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            mem_write_d      = 1'b1;
            mem_write_data_d = DATA_WIDTH'({shift_q, rx_data});
            mem_address_d    = addr_next;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      count_hi_q       <= '0;
      count_q          <= '0;
      shift_q          <= '0;
      byte_idx_q       <= '0;
      tmo_q            <= '0;
      mem_write_q      <= 1'b0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
      words_loaded_q   <= '0;
      cpu_hold_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      count_hi_q       <= count_hi_d;
      count_q          <= count_d;
      shift_q          <= shift_d;
      byte_idx_q       <= byte_idx_d;
      tmo_q            <= tmo_d;
      mem_write_q      <= mem_write_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      error_q          <= error_d;
      words_loaded_q   <= words_loaded_d;
      cpu_hold_q       <= cpu_hold_d;
    end
  end

  assign mem_write      = mem_write_q;
  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign words_loaded   = words_loaded_q;
  assign cpu_hold       = cpu_hold_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: scoreboard of expected (address, data) writes,
// checked by a monitor on every mem_write pulse; scenario tasks check status.

module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  logic        cpu_hold;

  int checks = 0;
  int failures = 0;
  int write_count = 0;
  logic [31:0] last_addr = '0;
  logic [63:0] exp_q[$];

  program_loader #(
    .MEMORY_DEPTH(32),
    .DATA_WIDTH(32),
    .BASE_ADDRESS(0),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .mem_write(mem_write),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .busy(busy),
    .done(done),
    .error(error),
    .words_loaded(words_loaded),
    .cpu_hold(cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor / scoreboard consumer
  always @(negedge clk) begin
    if (mem_write === 1'b1) begin
      logic [63:0] exp;
      write_count++;
      last_addr = mem_address;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h (no write expected)", mem_address, mem_write_data);
      end else begin
        exp = exp_q.pop_front();
        if ({mem_address, mem_write_data} !== exp) begin
          failures++;
          $display("FAIL write_content got addr=%h data=%h expected addr=%h data=%h",
                   mem_address, mem_write_data, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_not_busy(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++;
    if ({mem_write, mem_address, mem_write_data, busy, done, error, words_loaded, cpu_hold} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got mw=%b a=%h d=%h busy=%b done=%b err=%b wl=%0d hold=%b expected all zero",
               mem_write, mem_address, mem_write_data, busy, done, error, words_loaded, cpu_hold);
    end
    apply_reset();
  endtask

  task automatic test_normal();
    bit ok;
    logic [7:0] b [10] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    int w0 = write_count;
    exp_q.push_back({32'h0, 32'h12345678});
    exp_q.push_back({32'h4, 32'hAABBCCDD});
    pulse_start();
    checks++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL normal_busy got busy=%b hold=%b expected 1 1", busy, cpu_hold);
    end
    for (int i = 0; i < 10; i++) send_byte(b[i], 1);
    wait_not_busy(50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL normal_wait got busy=%b expected 0 within bound", busy); end
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || words_loaded !== 16'd2) begin
      failures++;
      $display("FAIL normal_status got done=%b err=%b hold=%b wl=%0d expected 1 0 0 2", done, error, cpu_hold, words_loaded);
    end
    checks++;
    if (write_count - w0 !== 2 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL normal_writes got %0d writes, %0d pending expected 2 writes 0 pending", write_count - w0, exp_q.size());
    end
  endtask

  task automatic test_zero_count();
    int w0 = write_count;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL zero_count got err=%b busy=%b hold=%b done=%b expected 1 0 1 0", error, busy, cpu_hold, done);
    end
    repeat (3) @(posedge clk); #1;
    checks++;
    if (write_count !== w0) begin
      failures++;
      $display("FAIL zero_count_writes got %0d expected 0", write_count - w0);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [7:0] d [128];
    int w0;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h21, 0);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL overflow_count got err=%b busy=%b hold=%b expected 1 0 1", error, busy, cpu_hold);
    end
    for (int i = 0; i < 128; i++) d[i] = 8'($urandom);
    for (int w = 0; w < 32; w++)
      exp_q.push_back({32'(4 * w), d[4*w], d[4*w+1], d[4*w+2], d[4*w+3]});
    w0 = write_count;
    pulse_start();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL restart_clear got err=%b busy=%b expected 0 1", error, busy);
    end
    send_byte(8'h00, $urandom_range(0, 3));
    send_byte(8'h20, $urandom_range(0, 3));
    for (int i = 0; i < 128; i++) send_byte(d[i], $urandom_range(0, 3));
    wait_not_busy(50, ok);
    checks++;
    if (!ok || done !== 1'b1 || error !== 1'b0 || words_loaded !== 16'd32) begin
      failures++;
      $display("FAIL max_load got ok=%b done=%b err=%b wl=%0d expected 1 1 0 32", ok, done, error, words_loaded);
    end
    checks++;
    if (write_count - w0 !== 32 || last_addr !== 32'h7C || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL max_load_writes got %0d writes last=%h pending=%0d expected 32 7c 0",
               write_count - w0, last_addr, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int err_cycle = -1;
    int w0 = write_count;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (error === 1'b1 && err_cycle < 0) err_cycle = k;
    end
    checks++;
    if (err_cycle !== 16) begin
      failures++;
      $display("FAIL timeout_cycle got error after %0d cycles expected 16", err_cycle);
    end
    checks++;
    if (write_count !== w0 || cpu_hold !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_state got writes=%0d hold=%b busy=%b expected 0 1 0", write_count - w0, cpu_hold, busy);
    end
    // Byte exactly on the terminal cycle must keep the frame alive.
    exp_q.push_back({32'h0, 32'hABCDEF01});
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 15);
    send_byte(8'hEF, 0);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_terminal_byte got err=%b busy=%b expected 0 1", error, busy);
    end
    send_byte(8'h01, 0);
    wait_not_busy(20, ok);
    checks++;
    if (!ok || done !== 1'b1 || words_loaded !== 16'd1 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL timeout_terminal_done got ok=%b done=%b wl=%0d pending=%0d expected 1 1 1 0",
               ok, done, words_loaded, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] b [14];
    int w0 = write_count;
    b[0] = 8'h00;
    b[1] = 8'h03;
    for (int i = 0; i < 12; i++) b[i+2] = 8'(8'hA0 + 8'(i * 7));
    for (int w = 0; w < 3; w++)
      exp_q.push_back({32'(4 * w), b[4*w+2], b[4*w+3], b[4*w+4], b[4*w+5]});
    pulse_start();
    for (int i = 0; i < 14; i++) begin
      rx_data  = b[i];
      rx_valid = 1'b1;
      start    = (i == 7);
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    wait_not_busy(20, ok);
    checks++;
    if (!ok || done !== 1'b1 || error !== 1'b0 || words_loaded !== 16'd3) begin
      failures++;
      $display("FAIL b2b_status got ok=%b done=%b err=%b wl=%0d expected 1 1 0 3", ok, done, error, words_loaded);
    end
    checks++;
    if (write_count - w0 !== 3 || last_addr !== 32'h8 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL b2b_writes got %0d writes last=%h pending=%0d expected 3 8 0", write_count - w0, last_addr, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int w0;
    exp_q.push_back({32'h0, 32'h11223344});
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    reset = 1'b1;
    #2;
    checks++;
    if ({mem_write, mem_address, mem_write_data, busy, done, error, words_loaded, cpu_hold} !== '0) begin
      failures++;
      $display("FAIL reset_mid got mw=%b a=%h d=%h busy=%b done=%b err=%b wl=%0d hold=%b expected all zero",
               mem_write, mem_address, mem_write_data, busy, done, error, words_loaded, cpu_hold);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL reset_mid_first_word got pending=%0d expected 0", exp_q.size());
    end
    w0 = write_count;
    exp_q.push_back({32'h0, 32'h01020304});
    pulse_start();
    send_byte(8'h00, 1);
    send_byte(8'h01, 1);
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'h03, 1);
    send_byte(8'h04, 1);
    wait_not_busy(20, ok);
    checks++;
    if (!ok || done !== 1'b1 || words_loaded !== 16'd1 || write_count - w0 !== 1 || exp_q.size() !== 0) begin
      failures++;
      $display("FAIL reset_mid_reload got ok=%b done=%b wl=%0d writes=%0d pending=%0d expected 1 1 1 1 0",
               ok, done, words_loaded, write_count - w0, exp_q.size());
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    #1;
    test_reset();
    test_normal();
    test_zero_count();
    test_overflow();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got simulation still running expected finish");
    $fatal(1, "time limit");
  end

endmodule
